// File: rtl/ssd_pkg.sv
// Shared constants for the 7-segment readback path: active-low glyph
// patterns {G..A} for each hex nibble and the digit index type.
package ssd_pkg;
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [1:0] digit_idx_t;
endpackage

// File: rtl/seg7_decode.sv
// Inverse of the hex display encoder: active-low segment pattern to nibble.
// Anything that is not one of the 16 glyphs is flagged and reads as 0.
module seg7_decode
  import ssd_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       illegal_o,
  output logic [3:0] nibble_o
);
  always_comb begin
    illegal_o = 1'b0;
    nibble_o  = 4'h0;
    case (seg_i)
      GLYPH_0: nibble_o = 4'h0;
      GLYPH_1: nibble_o = 4'h1;
      GLYPH_2: nibble_o = 4'h2;
      GLYPH_3: nibble_o = 4'h3;
      GLYPH_4: nibble_o = 4'h4;
      GLYPH_5: nibble_o = 4'h5;
      GLYPH_6: nibble_o = 4'h6;
      GLYPH_7: nibble_o = 4'h7;
      GLYPH_8: nibble_o = 4'h8;
      GLYPH_9: nibble_o = 4'h9;
      GLYPH_A: nibble_o = 4'hA;
      GLYPH_B: nibble_o = 4'hB;
      GLYPH_C: nibble_o = 4'hC;
      GLYPH_D: nibble_o = 4'hD;
      GLYPH_E: nibble_o = 4'hE;
      GLYPH_F: nibble_o = 4'hF;
      default: illegal_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/ssd_readback.sv
// Samples the multiplexed anode/cathode bus, accepts each digit once per
// stable anode dwell, and publishes a frame once all four digits are captured.
module ssd_readback
  import ssd_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  an_i,
  input  logic [6:0]  seg_i,
  output logic [15:0] value_o,
  output logic        frame_valid_o,
  output logic [3:0]  err_o,
  output logic        stale_o
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYCLES);

  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc_q, acc_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [3:0]    mask_q, mask_d;
  logic [15:0]   shadow_q;
  logic [3:0]    shadow_err_q;
  logic [15:0]   value_q;
  logic [3:0]    err_q;
  logic          frame_valid_q, stale_q;

  logic          phase_vld, match, accept, publish, tmo_hit;
  digit_idx_t    idx;
  logic          dec_ill;
  logic [3:0]    dec_nib;

  seg7_decode u_dec (
    .seg_i    (seg_i),
    .illegal_o(dec_ill),
    .nibble_o (dec_nib)
  );

  // Exactly one anode low selects a digit; anything else is an idle sample.
  always_comb begin
    phase_vld = 1'b1;
    idx       = 2'd0;
    case (an_i)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: phase_vld = 1'b0;
    endcase
  end

  assign match   = phase_vld && (an_i == an_q) && (seg_i == seg_q);
  assign publish = (mask_q == 4'hF);

  always_comb begin
    if (!phase_vld)             cnt_d = '0;
    else if (!match)            cnt_d = CW'(1);
    else if (cnt_q == STABLE_MAX) cnt_d = cnt_q;
    else                        cnt_d = cnt_q + CW'(1);

    // Any change of the sample reopens the dwell for a single new accept.
    accept = (cnt_d == STABLE_MAX) && !(match && acc_q);
    acc_d  = accept || (match && acc_q);

    if (accept)              tmo_d = '0;
    else if (tmo_q == TMO_MAX) tmo_d = tmo_q;
    else                     tmo_d = tmo_q + TW'(1);
    tmo_hit = (tmo_d == TMO_MAX);

    mask_d = mask_q;
    if (publish) mask_d = 4'h0;
    if (accept)  mask_d[idx] = 1'b1;
    if (tmo_hit) mask_d = 4'h0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      an_q          <= 4'hF;
      seg_q         <= SEG_BLANK;
      cnt_q         <= '0;
      acc_q         <= 1'b0;
      tmo_q         <= '0;
      mask_q        <= 4'h0;
      shadow_q      <= 16'h0000;
      shadow_err_q  <= 4'h0;
      value_q       <= 16'h0000;
      err_q         <= 4'h0;
      frame_valid_q <= 1'b0;
      stale_q       <= 1'b1;
    end else begin
      an_q          <= an_i;
      seg_q         <= seg_i;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      tmo_q         <= tmo_d;
      mask_q        <= mask_d;
      frame_valid_q <= publish;
      if (accept) begin
        shadow_q[{idx, 2'b00} +: 4] <= dec_nib;
        shadow_err_q[idx]           <= dec_ill;
      end
      if (publish) begin
        value_q <= shadow_q;
        err_q   <= shadow_err_q;
        stale_q <= 1'b0;
      end
      if (tmo_hit) stale_q <= 1'b1;
    end
  end

  assign value_o       = value_q;
  assign err_o         = err_q;
  assign frame_valid_o = frame_valid_q;
  assign stale_o       = stale_q;
endmodule
